// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared FSM encoding and frame counter width for axis_frame_tx
package axis_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        SEND = 1'b1
    } axis_state_e;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/axis_frame_buf.sv
// rtl/axis_frame_buf.sv - frame beat storage: synchronous write, asynchronous read
module axis_frame_buf #(
    parameter int data_width = 8,
    parameter int depth      = 8,
    parameter int addr_w     = 3
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [addr_w-1:0]     wr_addr_i,
    input  logic [data_width-1:0] wr_data_i,
    input  logic [addr_w-1:0]     rd_addr_i,
    output logic [data_width-1:0] rd_data_o
);

    logic [data_width-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_frame_tx.sv
// rtl/axis_frame_tx.sv - store-and-forward frame buffer with AXI-Stream master output
// Optional frame counter enabled by defining AXIS_FRAME_TX_CNT_EN.
module axis_frame_tx
    import axis_pkg::*;
#(
    parameter int data_width = 8,
    parameter int depth      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [data_width-1:0]  wr_data,
    input  logic                   wr_valid,
    input  logic                   wr_last,
    output logic                   wr_ready,
    output logic [data_width-1:0]  m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int AW = $clog2(depth);
    // One extra bit so wr_ptr can hold the beat count of a full frame.
    localparam int PW = AW + 1;

    axis_state_e           state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [data_width-1:0] rd_data;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  wr_at_end;
    logic                  rd_is_last;

    assign wr_fire    = (state_q == LOAD) && wr_valid;
    assign rd_fire    = (state_q == SEND) && m_tready;
    assign wr_at_end  = (wr_ptr_q == PW'(depth - 1));
    assign rd_is_last = (rd_ptr_q == (wr_ptr_q - PW'(1)));

    axis_frame_buf #(
        .data_width (data_width),
        .depth      (depth),
        .addr_w     (AW)
    ) u_buf (
        .clk        (clk),
        .wr_en_i    (wr_fire),
        .wr_addr_i  (wr_ptr_q[AW-1:0]),
        .wr_data_i  (wr_data),
        .rd_addr_i  (rd_ptr_q[AW-1:0]),
        .rd_data_o  (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case (state_q)
            LOAD: begin
                if (wr_fire) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (wr_last || wr_at_end) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (rd_fire) begin
                    if (rd_is_last) begin
                        state_d  = LOAD;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Outputs decode from registered state only, so they stay stable while stalled.
    always_comb begin
        wr_ready = 1'b0;
        busy     = 1'b0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tdata  = '0;
        case (state_q)
            LOAD: wr_ready = 1'b1;
            SEND: begin
                busy     = 1'b1;
                m_tvalid = 1'b1;
                m_tlast  = rd_is_last;
                m_tdata  = rd_data;
            end
            default: wr_ready = 1'b0;
        endcase
    end

`ifdef AXIS_FRAME_TX_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count_q <= '0;
        end else if (rd_fire && rd_is_last) begin
            frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_axis_frame_tx.sv
// tb/tb_axis_frame_tx.sv - directed self-checking bench for axis_frame_tx
module tb_axis_frame_tx;

    logic        clk;
    logic        reset;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_last;
    logic        wr_ready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        busy;
    logic [15:0] frame_count;

    int checks   = 0;
    int failures = 0;

    axis_frame_tx #(
        .data_width (8),
        .depth      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_last     (wr_last),
        .wr_ready    (wr_ready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .busy        (busy),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic load_beat(input logic [7:0] d, input logic last);
        wr_data  = d;
        wr_valid = 1'b1;
        wr_last  = last;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_data  = 8'h00;
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        wr_data  = 8'h00;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({wr_ready, busy, m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b v=%b l=%b d=%h, want 1 0 0 0 00",
                     wr_ready, busy, m_tvalid, m_tlast, m_tdata);
        end
        checks++;
        if (frame_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_frame_count: got %0d, want 0", frame_count);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        m_tready = 1'b1;
        load_beat(8'h11, 1'b0);
        load_beat(8'h22, 1'b0);
        load_beat(8'h33, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({m_tvalid, m_tlast, busy, wr_ready, m_tdata} !== {1'b1, (i == 2), 1'b1, 1'b0, exp[i]}) begin
                failures++;
                $display("FAIL basic_beat%0d: got v=%b l=%b busy=%b rdy=%b d=%h, want 1 %b 1 0 %h",
                         i, m_tvalid, m_tlast, busy, wr_ready, m_tdata, (i == 2), exp[i]);
            end
            @(negedge clk);
        end
        checks++;
        if ({m_tvalid, busy, wr_ready, m_tdata} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL basic_after: got v=%b busy=%b rdy=%b d=%h, want 0 0 1 00",
                     m_tvalid, busy, wr_ready, m_tdata);
        end
    endtask

    task automatic test_stall;
        m_tready = 1'b1;
        load_beat(8'h11, 1'b0);
        load_beat(8'h22, 1'b0);
        load_beat(8'h33, 1'b1);
        checks++;
        if ({m_tvalid, m_tdata} !== {1'b1, 8'h11}) begin
            failures++;
            $display("FAIL stall_beat0: got v=%b d=%h, want 1 11", m_tvalid, m_tdata);
        end
        @(negedge clk);
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b0, 8'h22}) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b l=%b d=%h, want 1 0 22",
                         i, m_tvalid, m_tlast, m_tdata);
            end
            @(negedge clk);
        end
        checks++;
        if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b0, 8'h22}) begin
            failures++;
            $display("FAIL stall_release: got v=%b l=%b d=%h, want 1 0 22", m_tvalid, m_tlast, m_tdata);
        end
        m_tready = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b1, 8'h33}) begin
            failures++;
            $display("FAIL stall_last: got v=%b l=%b d=%h, want 1 1 33", m_tvalid, m_tlast, m_tdata);
        end
        @(negedge clk);
        checks++;
        if ({m_tvalid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL stall_after: got v=%b busy=%b, want 0 0", m_tvalid, busy);
        end
    endtask

    task automatic test_auto_close;
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load_beat(8'(i), 1'b0);
        end
        // Junk on the load side during SEND must be ignored.
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({m_tvalid, m_tlast, wr_ready, m_tdata} !== {1'b1, (i == 7), 1'b0, 8'(i)}) begin
                failures++;
                $display("FAIL auto_beat%0d: got v=%b l=%b rdy=%b d=%h, want 1 %b 0 %h",
                         i, m_tvalid, m_tlast, wr_ready, m_tdata, (i == 7), 8'(i));
            end
            if (i == 7) begin
                wr_valid = 1'b0;
                wr_data  = 8'h00;
            end
            @(negedge clk);
        end
        checks++;
        if ({m_tvalid, wr_ready} !== 2'b01) begin
            failures++;
            $display("FAIL auto_after: got v=%b rdy=%b, want 0 1", m_tvalid, wr_ready);
        end
    endtask

    task automatic test_single_beat;
        m_tready = 1'b1;
        load_beat(8'hA5, 1'b1);
        checks++;
        if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL single_beat: got v=%b l=%b d=%h, want 1 1 A5", m_tvalid, m_tlast, m_tdata);
        end
        @(negedge clk);
        checks++;
        if ({m_tvalid, wr_ready, busy, m_tdata} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL single_after: got v=%b rdy=%b busy=%b d=%h, want 0 1 0 00",
                     m_tvalid, wr_ready, busy, m_tdata);
        end
    endtask

    task automatic test_reset_mid_send;
        m_tready = 1'b1;
        load_beat(8'h01, 1'b0);
        load_beat(8'h02, 1'b0);
        load_beat(8'h03, 1'b1);
        @(negedge clk);
        checks++;
        if ({m_tvalid, m_tdata} !== {1'b1, 8'h02}) begin
            failures++;
            $display("FAIL midrst_beat1: got v=%b d=%h, want 1 02", m_tvalid, m_tdata);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({m_tvalid, m_tlast, busy, wr_ready, m_tdata} !== {1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL midrst_immediate: got v=%b l=%b busy=%b rdy=%b d=%h, want 0 0 0 1 00",
                     m_tvalid, m_tlast, busy, wr_ready, m_tdata);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (m_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_idle: got v=%b, want 0", m_tvalid);
            end
        end
        load_beat(8'h5A, 1'b1);
        checks++;
        if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b1, 8'h5A}) begin
            failures++;
            $display("FAIL midrst_new: got v=%b l=%b d=%h, want 1 1 5A", m_tvalid, m_tlast, m_tdata);
        end
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_new_after: got v=%b, want 0", m_tvalid);
        end
    endtask

    // Two frames with the second one offered while tlast is still on the bus.
    task automatic test_back_to_back;
        logic [15:0] exp_cnt;
        m_tready = 1'b1;
        load_beat(8'hB1, 1'b1);
        checks++;
        if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b1, 8'hB1}) begin
            failures++;
            $display("FAIL b2b_first: got v=%b l=%b d=%h, want 1 1 B1", m_tvalid, m_tlast, m_tdata);
        end
        wr_data  = 8'hB2;
        wr_valid = 1'b1;
        wr_last  = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_tvalid, wr_ready} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_gap: got v=%b rdy=%b, want 0 1", m_tvalid, wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_data  = 8'h00;
        checks++;
        if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b1, 8'hB2}) begin
            failures++;
            $display("FAIL b2b_second: got v=%b l=%b d=%h, want 1 1 B2", m_tvalid, m_tlast, m_tdata);
        end
        @(negedge clk);
`ifdef AXIS_FRAME_TX_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        checks++;
        if (frame_count !== exp_cnt) begin
            failures++;
            $display("FAIL frame_count: got %0d, want %0d", frame_count, exp_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_auto_close;
        test_single_beat;
        test_reset_mid_send;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
